// File: rtl/npu_pkg.sv
// Shared constants and types for the result RAM read path.
package npu_pkg;

  localparam int RAM_DEPTH  = 64;
  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 32;
  // Word counter is one bit wider than the address so it can hold a full RAM (64).
  localparam int RAM_CNT_W  = RAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/word_serializer.sv
// Holds one RAM word and hands it out a byte at a time, LSB first, under a
// valid/ready handshake. A load restarts at byte 0.
module word_serializer
  import npu_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              valid,
  input  logic              ready,
  output logic [7:0]        data,
  output logic              last_byte
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [DATA_W-1:0] word_reg;
  logic [IDX_W-1:0]  byte_idx_reg;
  logic [7:0]        lane [NBYTES];

  // Split the held word into byte lanes; lane 0 is the least significant byte.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign lane[gi] = word_reg[8*gi +: 8];
  end

  assign last_byte = (byte_idx_reg == LAST_IDX);
  // Drive zero whenever nothing is offered so the bus is quiet in idle and reset.
  assign data      = valid ? lane[byte_idx_reg] : 8'h00;

  // Capture a new word on load; step to the next byte on each accepted non-final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg     <= '0;
      byte_idx_reg <= '0;
    end else if (load) begin
      word_reg     <= load_word;
      byte_idx_reg <= '0;
    end else if (valid && ready && !last_byte) begin
      byte_idx_reg <= byte_idx_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/result_ram_reader.sv
// Drains a run of result RAM words onto a byte stream. Each word costs one
// fetch cycle plus one cycle per byte when the consumer is always ready.
module result_ram_reader
  import npu_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [RAM_ADDR_W-1:0] base_addr,
  input  logic [RAM_CNT_W-1:0]  count,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [RAM_CNT_W-1:0]  DEPTH_CNT = RAM_CNT_W'(DEPTH);
  localparam logic [RAM_CNT_W-1:0]  ONE_CNT   = RAM_CNT_W'(1);
  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = RAM_ADDR_W'(DEPTH - 1);

  rd_state_t             state_reg, state_next;
  logic [RAM_ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [RAM_CNT_W-1:0]  words_left_reg, words_left_next;
  logic [RAM_CNT_W-1:0]  count_clamped;
  logic                  load;
  logic                  last_byte;

  // Requests larger than the RAM are trimmed to one full pass.
  assign count_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
  assign ram_addr      = cur_addr_reg;

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_word (ram_dout),
    .valid     (m_valid),
    .ready     (m_ready),
    .data      (m_data),
    .last_byte (last_byte)
  );

  // State, address and word counters; reset abandons any drain in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cur_addr_reg   <= '0;
      words_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      words_left_reg <= words_left_next;
    end
  end

  // Next state and outputs; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    words_left_next = words_left_reg;
    load            = 1'b0;
    m_valid         = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cur_addr_next   = base_addr;
          words_left_next = count_clamped;
          state_next      = (count_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        m_valid = 1'b1;
        if (m_ready && last_byte) begin
          words_left_next = words_left_reg - ONE_CNT;
          cur_addr_next   = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + RAM_ADDR_W'(1);
          state_next      = (words_left_reg == ONE_CNT) ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
